alarm_ctrl: RTL and testbench
=============================

Name: alarm_ctrl

Overview:
Alarm scheduler for the hour/min/sec clock datapath. Holds a programmable alarm time, compares it against the running clock on each one-second tick, and sequences the buzzer enable through ring, snooze and stop. Sits between the time counters/switch logic and the buzzer melody generator, whose enable input is driven by o_buzz_en.

Parameters:
RING_SEC, 60, seconds the buzzer rings before auto-stop (legal range 1..65535)
SNOOZE_SEC, 300, seconds of silence after a snooze request (legal range 1..65535)
MAX_SNOOZE, 3, snoozes allowed per alarm event; further snooze requests are ignored (legal range 0..15)

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
i_sec_tick  input  1  one-cycle pulse in the clk domain, once per second
i_sec  input  6  current seconds, 0..59
i_min  input  6  current minutes, 0..59
i_hour  input  6  current hours, 0..23
i_set_mode  input  1  level; 1 = alarm setup requested
i_pos  input  1  setup field select: 0 = minute, 1 = hour
i_inc_pulse  input  1  one-cycle pulse; increments the selected field
i_arm_toggle  input  1  one-cycle pulse; toggles the armed flag
i_stop_pulse  input  1  one-cycle pulse; stops the current alarm event
i_snooze_pulse  input  1  one-cycle pulse; snooze request
o_alarm_min  output  6  programmed alarm minute
o_alarm_hour  output  6  programmed alarm hour
o_armed  output  1  alarm armed flag
o_buzz_en  output  1  buzzer enable (registered)
o_state  output  2  0 IDLE, 1 SETUP, 2 RINGING, 3 SNOOZE

Behaviour:
- Reset: state IDLE; o_alarm_min=0, o_alarm_hour=0, o_armed=0, o_buzz_en=0; 16-bit second counter=0; 4-bit snooze count=0. All outputs registered.
- IDLE:
  - i_set_mode=1 -> SETUP on the next cycle.
  - Match -> RINGING on the next cycle; counter loaded with RING_SEC; snooze count cleared. Match requires: i_sec_tick=1, o_armed=1, i_hour==o_alarm_hour, i_min==o_alarm_min, i_sec==0, all sampled in the same cycle.
  - If set_mode and match occur in the same cycle, SETUP wins.
- SETUP:
  - i_set_mode=0 -> IDLE on the next cycle.
  - i_inc_pulse with i_pos=0: minute increments, wrapping 59->0 with no carry into the hour.
  - i_inc_pulse with i_pos=1: hour increments, wrapping 23->0.
  - Match detection is suppressed; o_buzz_en=0.
- RINGING: o_buzz_en=1 in every cycle where o_state=2. Priority, highest first:
  - i_stop_pulse -> IDLE.
  - i_snooze_pulse with snooze count < MAX_SNOOZE -> SNOOZE; counter=SNOOZE_SEC; snooze count +1.
  - i_sec_tick: counter decrements. If the counter is 1 when the tick arrives, go to IDLE instead. The alarm therefore rings for exactly RING_SEC ticks.
  - A snooze request at snooze count == MAX_SNOOZE is ignored.
- SNOOZE: o_buzz_en=0. Priority, highest first:
  - i_stop_pulse -> IDLE.
  - i_sec_tick with counter==1 -> RINGING; counter=RING_SEC.
  - Otherwise each tick decrements the counter.
  - i_snooze_pulse is ignored.
- Arm/disarm:
  - i_arm_toggle toggles o_armed in any state.
  - If the toggle leaves o_armed=0 while in RINGING or SNOOZE, go to IDLE next cycle; this has priority over every other pulse.
  - Stop and auto-stop leave o_armed unchanged.
- i_set_mode during RINGING/SNOOZE is ignored; SETUP is entered only from IDLE.
- Re-trigger guard: a match is evaluated only in IDLE on a tick with i_sec==0. An event that stops inside its own matching minute cannot re-trigger until the next day.
- Arithmetic: counter is 16-bit unsigned and never decrements below 1 in RINGING/SNOOZE. Snooze count saturates at MAX_SNOOZE.
- Reset mid-event: buzzer off immediately (asynchronous); the alarm time and armed flag are lost.

Test Plan:
- After reset: all outputs 0. In SETUP, 7 minute pulses give o_alarm_min=7. With i_pos=1, 25 hour pulses give o_alarm_hour=1 (wrap). Leave SETUP -> o_state=0.
- Armed, alarm 01:07. Drive i_hour=1, i_min=7, i_sec=0 with a tick -> o_state=2, o_buzz_en=1 the next cycle. After 60 further ticks -> IDLE, o_buzz_en=0, o_armed=1.
- RINGING: snooze pulse -> o_state=3, o_buzz_en=0. Exactly 300 ticks later -> RINGING again. A 4th snooze (MAX_SNOOZE=3) is ignored; o_state stays 2.
- Stop pulse and snooze pulse in the same cycle while RINGING -> IDLE; snooze count unchanged.
- Disarm toggle during SNOOZE -> IDLE, o_armed=0. A matching tick afterwards -> no ring.
- Assert rst_n=0 mid-RINGING between clock edges -> o_buzz_en=0 and o_state=0 immediately, o_alarm_min/o_alarm_hour=0.

Source files
------------

// File: rtl/alarm_ctrl.sv
// rtl/alarm_ctrl.sv - alarm scheduler: programmable alarm time, ring/snooze/stop sequencing
module alarm_ctrl #(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sec_tick,
  input  logic [5:0] i_sec,
  input  logic [5:0] i_min,
  input  logic [5:0] i_hour,
  input  logic       i_set_mode,
  input  logic       i_pos,
  input  logic       i_inc_pulse,
  input  logic       i_arm_toggle,
  input  logic       i_stop_pulse,
  input  logic       i_snooze_pulse,
  output logic [5:0] o_alarm_min,
  output logic [5:0] o_alarm_hour,
  output logic       o_armed,
  output logic       o_buzz_en,
  output logic [1:0] o_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_RING   = 2'd2,
    S_SNOOZE = 2'd3
  } state_t;

  localparam logic [15:0] RING_LD   = 16'(RING_SEC);
  localparam logic [15:0] SNOOZE_LD = 16'(SNOOZE_SEC);
  localparam logic [3:0]  SNZ_MAX   = 4'(MAX_SNOOZE);

  state_t      state_q, state_d;
  logic [5:0]  min_q, min_d;
  logic [5:0]  hour_q, hour_d;
  logic        armed_q, armed_d;
  logic        buzz_q;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  snz_q, snz_d;
  logic        match;
  logic        disarm;

  // Only the top of a minute can match, so a stopped event cannot re-fire in its own minute.
  assign match  = i_sec_tick & armed_q & (i_hour == hour_q) & (i_min == min_q) & (i_sec == 6'd0);
  assign disarm = i_arm_toggle & armed_q;

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    hour_d  = hour_q;
    armed_d = armed_q ^ i_arm_toggle;
    cnt_d   = cnt_q;
    snz_d   = snz_q;
    case (state_q)
      S_IDLE: begin
        if (i_set_mode) begin
          state_d = S_SETUP;
        end else if (match) begin
          state_d = S_RING;
          cnt_d   = RING_LD;
          snz_d   = 4'd0;
        end
      end
      S_SETUP: begin
        if (i_inc_pulse) begin
          if (i_pos) hour_d = (hour_q == 6'd23) ? 6'd0 : hour_q + 6'd1;
          else       min_d  = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
        end
        if (!i_set_mode) state_d = S_IDLE;
      end
      S_RING: begin
        if (disarm || i_stop_pulse) begin
          state_d = S_IDLE;
        end else if (i_snooze_pulse && (snz_q < SNZ_MAX)) begin
          state_d = S_SNOOZE;
          cnt_d   = SNOOZE_LD;
          snz_d   = snz_q + 4'd1;
        end else if (i_sec_tick) begin
          if (cnt_q <= 16'd1) state_d = S_IDLE;
          else                cnt_d   = cnt_q - 16'd1;
        end
      end
      S_SNOOZE: begin
        if (disarm || i_stop_pulse) begin
          state_d = S_IDLE;
        end else if (i_sec_tick) begin
          if (cnt_q <= 16'd1) begin
            state_d = S_RING;
            cnt_d   = RING_LD;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      min_q   <= 6'd0;
      hour_q  <= 6'd0;
      armed_q <= 1'b0;
      buzz_q  <= 1'b0;
      cnt_q   <= 16'd0;
      snz_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      armed_q <= armed_d;
      buzz_q  <= (state_d == S_RING);
      cnt_q   <= cnt_d;
      snz_q   <= snz_d;
    end
  end

  assign o_alarm_min  = min_q;
  assign o_alarm_hour = hour_q;
  assign o_armed      = armed_q;
  assign o_buzz_en    = buzz_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb/tb_alarm_ctrl.sv - self-checking bench for alarm_ctrl with a behavioural alarm model
module tb_alarm_ctrl;
  localparam int RING = 60;
  localparam int SNZ  = 300;
  localparam int MAXS = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_sec_tick = 1'b0;
  logic [5:0] i_sec = '0, i_min = '0, i_hour = '0;
  logic       i_set_mode = 1'b0, i_pos = 1'b0, i_inc_pulse = 1'b0;
  logic       i_arm_toggle = 1'b0, i_stop_pulse = 1'b0, i_snooze_pulse = 1'b0;
  logic [5:0] o_alarm_min, o_alarm_hour;
  logic       o_armed, o_buzz_en;
  logic [1:0] o_state;

  int checks = 0;
  int failures = 0;

  // Behavioural model: phase name, ticks left in the current phase, snoozes used.
  int m_state, m_min, m_hour, m_armed, m_left, m_snz;

  alarm_ctrl #(.RING_SEC(RING), .SNOOZE_SEC(SNZ), .MAX_SNOOZE(MAXS)) dut (
    .clk(clk), .rst_n(rst_n), .i_sec_tick(i_sec_tick), .i_sec(i_sec), .i_min(i_min),
    .i_hour(i_hour), .i_set_mode(i_set_mode), .i_pos(i_pos), .i_inc_pulse(i_inc_pulse),
    .i_arm_toggle(i_arm_toggle), .i_stop_pulse(i_stop_pulse), .i_snooze_pulse(i_snooze_pulse),
    .o_alarm_min(o_alarm_min), .o_alarm_hour(o_alarm_hour), .o_armed(o_armed),
    .o_buzz_en(o_buzz_en), .o_state(o_state)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = 0; m_min = 0; m_hour = 0; m_armed = 0; m_left = 0; m_snz = 0;
  endtask

  task automatic model_update();
    int ns;
    int new_armed;
    ns = m_state;
    new_armed = m_armed ^ int'(i_arm_toggle);
    if (m_state == 0) begin
      if (i_set_mode) ns = 1;
      else if (i_sec_tick && m_armed == 1 && int'(i_hour) == m_hour && int'(i_min) == m_min && i_sec == 0) begin
        ns = 2; m_left = RING; m_snz = 0;
      end
    end else if (m_state == 1) begin
      if (i_inc_pulse && i_pos)  m_hour = (m_hour + 1) % 24;
      if (i_inc_pulse && !i_pos) m_min  = (m_min + 1) % 60;
      if (!i_set_mode) ns = 0;
    end else begin
      if ((i_arm_toggle && new_armed == 0) || i_stop_pulse) ns = 0;
      else if (m_state == 2 && i_snooze_pulse && m_snz < MAXS) begin
        ns = 3; m_left = SNZ; m_snz++;
      end else if (i_sec_tick) begin
        m_left--;
        if (m_left == 0) begin
          ns = (m_state == 2) ? 0 : 2;
          if (ns == 2) m_left = RING;
        end
      end
    end
    m_armed = new_armed;
    m_state = ns;
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    i_sec_tick = 0; i_inc_pulse = 0; i_arm_toggle = 0; i_stop_pulse = 0; i_snooze_pulse = 0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      i_sec_tick = 1;
      step();
    end
  endtask

  task automatic trigger();
    i_hour = 6'd1; i_min = 6'd7; i_sec = 6'd0; i_sec_tick = 1;
    step();
    i_sec = 6'd1;
  endtask

  task automatic test_reset();
    rst_n = 0; model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (o_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", o_state); end
    checks++; if (o_buzz_en !== 1'b0) begin failures++; $display("FAIL reset_buzz got=%0b exp=0", o_buzz_en); end
    checks++; if (o_armed !== 1'b0) begin failures++; $display("FAIL reset_armed got=%0b exp=0", o_armed); end
    checks++; if (o_alarm_min !== 6'd0) begin failures++; $display("FAIL reset_min got=%0d exp=0", o_alarm_min); end
    checks++; if (o_alarm_hour !== 6'd0) begin failures++; $display("FAIL reset_hour got=%0d exp=0", o_alarm_hour); end
    rst_n = 1;
    step();
  endtask

  task automatic test_setup();
    i_set_mode = 1; step();
    checks++; if (o_state !== 2'd1) begin failures++; $display("FAIL setup_enter got=%0d exp=1", o_state); end
    i_pos = 0;
    for (int k = 0; k < 7; k++) begin i_inc_pulse = 1; step(); end
    checks++; if (o_alarm_min !== 6'd7) begin failures++; $display("FAIL setup_min got=%0d exp=7", o_alarm_min); end
    i_pos = 1;
    for (int k = 0; k < 25; k++) begin i_inc_pulse = 1; step(); end
    checks++; if (o_alarm_hour !== 6'd1) begin failures++; $display("FAIL setup_hour_wrap got=%0d exp=1", o_alarm_hour); end
    checks++; if (o_alarm_min !== 6'd7) begin failures++; $display("FAIL setup_min_kept got=%0d exp=7", o_alarm_min); end
    i_pos = 0;
    for (int k = 0; k < 60; k++) begin i_inc_pulse = 1; step(); end
    checks++; if (o_alarm_min !== 6'd7 || o_alarm_hour !== 6'd1) begin failures++;
      $display("FAIL setup_min_nocarry got=%0d:%0d exp=1:7", o_alarm_hour, o_alarm_min); end
    i_set_mode = 0; step();
    checks++; if (o_state !== 2'd0) begin failures++; $display("FAIL setup_leave got=%0d exp=0", o_state); end
    i_arm_toggle = 1; step();
    checks++; if (o_armed !== 1'b1) begin failures++; $display("FAIL arm_on got=%0b exp=1", o_armed); end
  endtask

  task automatic test_ring();
    trigger();
    checks++; if (o_state !== 2'd2 || o_buzz_en !== 1'b1) begin failures++;
      $display("FAIL ring_start got=%0d/%0b exp=2/1", o_state, o_buzz_en); end
    ticks(RING - 1);
    checks++; if (o_state !== 2'd2 || o_buzz_en !== 1'b1) begin failures++;
      $display("FAIL ring_last_tick got=%0d/%0b exp=2/1", o_state, o_buzz_en); end
    ticks(1);
    checks++; if (o_state !== 2'd0 || o_buzz_en !== 1'b0 || o_armed !== 1'b1) begin failures++;
      $display("FAIL ring_autostop got=%0d/%0b/%0b exp=0/0/1", o_state, o_buzz_en, o_armed); end
  endtask

  task automatic test_snooze();
    trigger();
    for (int s = 1; s <= MAXS; s++) begin
      i_snooze_pulse = 1; step();
      checks++; if (o_state !== 2'd3 || o_buzz_en !== 1'b0) begin failures++;
        $display("FAIL snooze_enter_%0d got=%0d/%0b exp=3/0", s, o_state, o_buzz_en); end
      i_snooze_pulse = 1; ticks(SNZ - 1);
      checks++; if (o_state !== 2'd3) begin failures++; $display("FAIL snooze_hold_%0d got=%0d exp=3", s, o_state); end
      ticks(1);
      checks++; if (o_state !== 2'd2 || o_buzz_en !== 1'b1) begin failures++;
        $display("FAIL snooze_rering_%0d got=%0d/%0b exp=2/1", s, o_state, o_buzz_en); end
    end
    i_snooze_pulse = 1; step();
    checks++; if (o_state !== 2'd2 || o_buzz_en !== 1'b1) begin failures++;
      $display("FAIL snooze_max_ignored got=%0d/%0b exp=2/1", o_state, o_buzz_en); end
    i_stop_pulse = 1; i_snooze_pulse = 1; step();
    checks++; if (o_state !== 2'd0 || o_buzz_en !== 1'b0) begin failures++;
      $display("FAIL stop_beats_snooze got=%0d/%0b exp=0/0", o_state, o_buzz_en); end
  endtask

  task automatic test_disarm();
    trigger();
    i_snooze_pulse = 1; step();
    i_arm_toggle = 1; i_sec_tick = 1; step();
    checks++; if (o_state !== 2'd0 || o_armed !== 1'b0) begin failures++;
      $display("FAIL disarm_snooze got=%0d/%0b exp=0/0", o_state, o_armed); end
    trigger();
    checks++; if (o_state !== 2'd0 || o_buzz_en !== 1'b0) begin failures++;
      $display("FAIL disarmed_no_ring got=%0d/%0b exp=0/0", o_state, o_buzz_en); end
  endtask

  task automatic test_reset_mid();
    i_arm_toggle = 1; step();
    trigger();
    checks++; if (o_state !== 2'd2) begin failures++; $display("FAIL rst_pre_ring got=%0d exp=2", o_state); end
    @(negedge clk);
    rst_n = 0; model_reset();
    #1;
    checks++; if (o_buzz_en !== 1'b0 || o_state !== 2'd0) begin failures++;
      $display("FAIL rst_async got=%0d/%0b exp=0/0", o_state, o_buzz_en); end
    checks++; if (o_alarm_min !== 6'd0 || o_alarm_hour !== 6'd0 || o_armed !== 1'b0) begin failures++;
      $display("FAIL rst_async_regs got=%0d:%0d/%0b exp=0:0/0", o_alarm_hour, o_alarm_min, o_armed); end
    @(negedge clk);
    rst_n = 1;
    step();
  endtask

  task automatic test_random();
    logic [1:0] exp_state;
    i_set_mode = 0;
    for (int c = 0; c < 5000; c++) begin
      if ($urandom_range(0, 199) == 0) i_set_mode = ~i_set_mode;
      i_sec_tick     = ($urandom_range(0, 1) == 0);
      i_pos          = $urandom_range(0, 1);
      i_inc_pulse    = ($urandom_range(0, 3) == 0);
      i_arm_toggle   = ($urandom_range(0, 99) == 0);
      i_stop_pulse   = ($urandom_range(0, 299) == 0);
      i_snooze_pulse = ($urandom_range(0, 39) == 0);
      i_sec          = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom_range(0, 59));
      if ($urandom_range(0, 1) == 0) begin
        i_hour = 6'(m_hour); i_min = 6'(m_min);
      end else begin
        i_hour = 6'($urandom_range(0, 23)); i_min = 6'($urandom_range(0, 59));
      end
      step();
      exp_state = 2'(m_state);
      checks++;
      if ({o_state, o_buzz_en, o_armed, o_alarm_hour, o_alarm_min} !==
          {exp_state, (m_state == 2), (m_armed == 1), 6'(m_hour), 6'(m_min)}) begin
        failures++;
        $display("FAIL random_cycle_%0d got st=%0d bz=%0b arm=%0b %0d:%0d exp st=%0d bz=%0b arm=%0d %0d:%0d",
                 c, o_state, o_buzz_en, o_armed, o_alarm_hour, o_alarm_min,
                 m_state, (m_state == 2), m_armed, m_hour, m_min);
      end
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_setup();
    test_ring();
    test_snooze();
    test_disarm();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
